// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared types and default sizing for the TLB PLRU array
//
// Purpose : flush sequencer state encoding and default geometry used as
//           parameter defaults by tlb_plru_array and plru_tree.
// Ports   : none (package).
package tlb_pkg;

  localparam int D_SADDR = 64;
  localparam int D_SPAGE = 12;
  localparam int D_NSET  = 8;
  localparam int D_SPCID = 12;
  localparam int D_NWAY  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/tlb_plru_tree.sv
// rtl/tlb_plru_tree.sv - combinational tree-PLRU victim select and update
//
// Purpose : module plru_tree. Walks the NWAY-1 tree bits from the root to
//           produce the victim way, and produces the tree bits after an
//           access to acc_way (every node on its path points away from it).
// Ports   : bits      - current tree bits of one set (node i: kids 2i+1/2i+2)
//           acc_way   - way being accessed (hit or fill)
//           victim    - way the tree currently points at
//           next_bits - tree bits after accessing acc_way
module plru_tree
  import tlb_pkg::*;
#(
  parameter int NWAY = D_NWAY,
  localparam int SWAY = $clog2(NWAY)
) (
  input  logic [NWAY-2:0] bits,
  input  logic [SWAY-1:0] acc_way,
  output logic [SWAY-1:0] victim,
  output logic [NWAY-2:0] next_bits
);

  // Index width for the internal node numbers (at least one bit).
  localparam int SNODE = (NWAY > 2) ? $clog2(NWAY - 1) : 1;

  // Bit value 1 means the victim lies in the right subtree; the chosen
  // directions, MSB first, spell out the victim way number.
  always_comb begin : victim_walk
    int   node;
    logic b;
    victim = '0;
    node   = 0;
    b      = 1'b0;
    for (int l = 0; l < SWAY; l++) begin
      b      = bits[SNODE'(node)];
      victim = (victim << 1) | SWAY'(b);
      node   = 2 * node + 1 + int'(b);
    end
  end

  always_comb begin : update_walk
    int              node;
    logic [SWAY-1:0] w;
    logic            dir;
    next_bits = bits;
    node      = 0;
    w         = acc_way;
    dir       = 1'b0;
    for (int l = 0; l < SWAY; l++) begin
      dir                     = w[SWAY-1];
      next_bits[SNODE'(node)] = ~dir;
      w                       = w << 1;
      node                    = 2 * node + 1 + int'(dir);
    end
  end

endmodule

// File: rtl/tlb_plru_array.sv
// rtl/tlb_plru_array.sv - N-way set-associative PCID-tagged TLB with tree-PLRU
//
// Purpose : clocked lookup (1-cycle registered response), fill with victim
//           selection (same tag+pcid, else lowest invalid, else PLRU) and a
//           one-set-per-cycle flush sweep (all or by PCID).
// Ports   : clk, rst_n                      - clock, async active-low reset
//           lk_valid/lk_ready/lk_va/lk_pcid - lookup request
//           rsp_valid/rsp_hit/rsp_pa        - lookup response
//           fill_valid/fill_ready/fill_*    - fill from page walker
//           flush_req/flush_all/flush_pcid  - flush request (IDLE only)
//           flush_busy/flush_done           - flush status
module tlb_plru_array
  import tlb_pkg::*;
#(
  parameter int SADDR = D_SADDR,
  parameter int SPAGE = D_SPAGE,
  parameter int NSET  = D_NSET,
  parameter int SPCID = D_SPCID,
  parameter int NWAY  = D_NWAY
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   lk_valid,
  output logic                   lk_ready,
  input  logic [SADDR-1:0]       lk_va,
  input  logic [SPCID-1:0]       lk_pcid,
  output logic                   rsp_valid,
  output logic                   rsp_hit,
  output logic [SADDR-SPAGE-1:0] rsp_pa,
  input  logic                   fill_valid,
  output logic                   fill_ready,
  input  logic [SADDR-1:0]       fill_va,
  input  logic [SPCID-1:0]       fill_pcid,
  input  logic [SADDR-SPAGE-1:0] fill_pa,
  input  logic                   flush_req,
  input  logic                   flush_all,
  input  logic [SPCID-1:0]       flush_pcid,
  output logic                   flush_busy,
  output logic                   flush_done
);

  localparam int SIDX = $clog2(NSET);
  localparam int SWAY = $clog2(NWAY);
  localparam int STAG = SADDR - SPAGE - SIDX;
  localparam int SPPN = SADDR - SPAGE;
  localparam int NENT = NSET * NWAY;

  // Entry storage; entry index is {set, way}.
  logic [STAG-1:0]  tag_q  [NENT];
  logic [SPCID-1:0] pcid_q [NENT];
  logic [SPPN-1:0]  pa_q   [NENT];
  logic [NENT-1:0]  valid_q;
  logic [NWAY-2:0]  plru_q [NSET];

  state_t           state_q, state_d;
  logic [SIDX-1:0]  sweep_q;
  logic             fall_q;
  logic [SPCID-1:0] fpcid_q;

  logic [SIDX-1:0] lk_set, fill_set;
  logic [STAG-1:0] lk_tag, fill_tag;
  logic [NWAY-1:0] lk_hit_vec, fill_match_vec, fill_inv_vec;
  logic [SWAY-1:0] lk_hit_way, fill_way, fill_victim, lk_victim_unused;
  logic [NWAY-2:0] lk_next_bits, fill_next_bits;
  logic            lk_fire, fill_fire, lk_hit, flush_start, last_set;
  logic            unused_va_bits;

  assign lk_set   = lk_va[SPAGE +: SIDX];
  assign lk_tag   = lk_va[SADDR-1 -: STAG];
  assign fill_set = fill_va[SPAGE +: SIDX];
  assign fill_tag = fill_va[SADDR-1 -: STAG];
  assign unused_va_bits = ^{lk_va[SPAGE-1:0], fill_va[SPAGE-1:0]};

  function automatic logic [SWAY-1:0] first_set(input logic [NWAY-1:0] vec);
    logic [NWAY-1:0] v;
    logic            found;
    first_set = '0;
    v         = vec;
    found     = 1'b0;
    for (int w = 0; w < NWAY; w++) begin
      if (v[0] && !found) begin
        first_set = SWAY'(w);
        found     = 1'b1;
      end
      v = v >> 1;
    end
  endfunction

  for (genvar w = 0; w < NWAY; w++) begin : g_way
    assign lk_hit_vec[w] = valid_q[{lk_set, SWAY'(w)}]
                         && (tag_q[{lk_set, SWAY'(w)}] == lk_tag)
                         && (pcid_q[{lk_set, SWAY'(w)}] == lk_pcid);
    assign fill_match_vec[w] = valid_q[{fill_set, SWAY'(w)}]
                             && (tag_q[{fill_set, SWAY'(w)}] == fill_tag)
                             && (pcid_q[{fill_set, SWAY'(w)}] == fill_pcid);
    assign fill_inv_vec[w] = ~valid_q[{fill_set, SWAY'(w)}];
  end

  assign lk_hit     = |lk_hit_vec;
  assign lk_hit_way = first_set(lk_hit_vec);

  // Overwriting a matching entry keeps the set free of duplicates.
  always_comb begin
    fill_way = fill_victim;
    if (|fill_match_vec) begin
      fill_way = first_set(fill_match_vec);
    end else if (|fill_inv_vec) begin
      fill_way = first_set(fill_inv_vec);
    end
  end

  plru_tree #(.NWAY(NWAY)) u_lk_plru (
    .bits      (plru_q[lk_set]),
    .acc_way   (lk_hit_way),
    .victim    (lk_victim_unused),
    .next_bits (lk_next_bits)
  );

  plru_tree #(.NWAY(NWAY)) u_fill_plru (
    .bits      (plru_q[fill_set]),
    .acc_way   (fill_way),
    .victim    (fill_victim),
    .next_bits (fill_next_bits)
  );

  // Flush request takes the cycle: neither fill nor lookup is accepted.
  always_comb begin
    state_d    = state_q;
    lk_ready   = 1'b0;
    fill_ready = 1'b0;
    flush_busy = 1'b0;
    case (state_q)
      IDLE: begin
        fill_ready = ~flush_req;
        lk_ready   = ~flush_req & ~fill_valid;
        if (flush_req) state_d = FLUSH;
      end
      FLUSH: begin
        flush_busy = 1'b1;
        if (last_set) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign last_set    = (sweep_q == SIDX'(NSET - 1));
  assign lk_fire     = lk_valid & lk_ready;
  assign fill_fire   = fill_valid & fill_ready;
  assign flush_start = (state_q == IDLE) & flush_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      plru_q     <= '{default: '0};
      sweep_q    <= '0;
      fall_q     <= 1'b0;
      fpcid_q    <= '0;
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_pa     <= '0;
      flush_done <= 1'b0;
    end else begin
      rsp_valid  <= lk_fire;
      rsp_hit    <= lk_fire & lk_hit;
      rsp_pa     <= (lk_fire && lk_hit) ? pa_q[{lk_set, lk_hit_way}] : '0;
      flush_done <= (state_q == FLUSH) && last_set;

      if (flush_start) begin
        fall_q  <= flush_all;
        fpcid_q <= flush_pcid;
        sweep_q <= '0;
      end else if (state_q == FLUSH) begin
        for (int w = 0; w < NWAY; w++) begin
          if (fall_q || (pcid_q[{sweep_q, SWAY'(w)}] == fpcid_q))
            valid_q[{sweep_q, SWAY'(w)}] <= 1'b0;
        end
        if (fall_q) plru_q[sweep_q] <= '0;
        // Wraps back to 0 after the last set.
        sweep_q <= sweep_q + 1'b1;
      end

      if (lk_fire && lk_hit) plru_q[lk_set] <= lk_next_bits;

      if (fill_fire) begin
        valid_q[{fill_set, fill_way}] <= 1'b1;
        plru_q[fill_set]              <= fill_next_bits;
      end
    end
  end

  // Payload needs no reset: nothing reads it while valid is clear.
  always_ff @(posedge clk) begin
    if (fill_fire) begin
      tag_q[{fill_set, fill_way}]  <= fill_tag;
      pcid_q[{fill_set, fill_way}] <= fill_pcid;
      pa_q[{fill_set, fill_way}]   <= fill_pa;
    end
  end

  a_onehot_hit: assert property (@(posedge clk) disable iff (!rst_n)
    lk_fire |-> $onehot0(lk_hit_vec))
    else $error("multi-way TLB hit");

endmodule
